// File: rtl/ifid_elastic_stage.sv
// Elastic IF/ID stage: OUT + SKID entries behind a valid/ready handshake.
// if_ready is a pure function of the state flop, so decode stalls never reach fetch combinationally.
module ifid_elastic_stage #(
    parameter int INSTR_W = 32,
    parameter int PC_W = 32,
    parameter logic [INSTR_W-1:0] NOP_VALUE = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [INSTR_W-1:0] if_instruction,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [PC_W-1:0]    if_pcadd4,
    input  logic               if_is_bds,
    input  logic               if_flush,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [PC_W-1:0]    id_pcadd4,
    output logic [PC_W-1:0]    id_restart_pc,
    output logic               id_is_bds,
    output logic               id_is_flushed,
    output logic [1:0]         occupancy
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pcadd4;
        logic [PC_W-1:0]    rpc;
        logic               bds;
        logic               flushed;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    entry_t          out_q, out_d;
    entry_t          skid_q, skid_d;
    logic [PC_W-1:0] last_rpc_q, last_rpc_d;

    logic   accept;
    logic   consume;
    entry_t new_e;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            last_rpc_q <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            last_rpc_q <= last_rpc_d;
        end
    end

    always_comb begin
        accept  = if_valid & if_ready;
        consume = id_valid & id_ready;

        new_e.instr   = if_instruction;
        new_e.pcadd4  = if_pcadd4;
        // A delay slot restarts at its branch, so it inherits the last non-BDS PC
        new_e.rpc     = if_is_bds ? last_rpc_q : if_pc;
        new_e.bds     = if_is_bds;
        new_e.flushed = 1'b0;

        state_d    = state_q;
        out_d      = out_q;
        skid_d     = skid_q;
        last_rpc_d = (accept & ~if_is_bds) ? if_pc : last_rpc_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = new_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept & consume) begin
                    out_d = new_e;
                end else if (accept) begin
                    skid_d  = new_e;
                    state_d = FULL;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush squashes what survives the edge; the skid entry is simply dropped
        if (if_flush) begin
            if (state_d == FULL) begin
                state_d = ONE;
            end
            if (state_d != EMPTY) begin
                out_d.instr   = NOP_VALUE;
                out_d.flushed = 1'b1;
            end
        end
    end

    always_comb begin
        if_ready       = (state_q != FULL);
        id_valid       = (state_q != EMPTY);
        occupancy      = state_q;
        id_instruction = out_q.instr;
        id_pcadd4      = out_q.pcadd4;
        id_restart_pc  = out_q.rpc;
        id_is_bds      = out_q.bds;
        id_is_flushed  = out_q.flushed;
    end

endmodule

// File: tb/tb_ifid_elastic_stage.sv
// Randomised scoreboard bench for ifid_elastic_stage.
// A queue of held beats is the reference; a negedge monitor compares the DUT to its head.
module tb_ifid_elastic_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_instruction = '0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_pcadd4 = '0;
    logic        if_is_bds = 1'b0;
    logic        if_flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instruction;
    logic [31:0] id_pcadd4;
    logic [31:0] id_restart_pc;
    logic        id_is_bds;
    logic        id_is_flushed;
    logic [1:0]  occupancy;

    ifid_elastic_stage #(
        .INSTR_W(32),
        .PC_W(32),
        .NOP_VALUE(NOP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_instruction(if_instruction),
        .if_pc(if_pc),
        .if_pcadd4(if_pcadd4),
        .if_is_bds(if_is_bds),
        .if_flush(if_flush),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_instruction(id_instruction),
        .id_pcadd4(id_pcadd4),
        .id_restart_pc(id_restart_pc),
        .id_is_bds(id_is_bds),
        .id_is_flushed(id_is_flushed),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcadd4;
        logic [31:0] rpc;
        logic        bds;
        logic        fl;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_last = '0;
    int          vectors = 0;
    int          miscompares = 0;

    // Reference: held beats in order, at most two; flush keeps only the head
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_last = '0;
        end else begin : upd
            bit   acc;
            bit   con;
            ent_t e;
            acc = if_valid && (mq.size() < 2);
            con = id_ready && (mq.size() > 0);
            if (con) void'(mq.pop_front());
            if (acc) begin
                e.instr  = if_instruction;
                e.pcadd4 = if_pcadd4;
                e.rpc    = if_is_bds ? m_last : if_pc;
                e.bds    = if_is_bds;
                e.fl     = 1'b0;
                mq.push_back(e);
                if (!if_is_bds) m_last = if_pc;
            end
            if (if_flush) begin
                while (mq.size() > 1) void'(mq.pop_back());
                if (mq.size() == 1) begin
                    e       = mq[0];
                    e.instr = NOP;
                    e.fl    = 1'b1;
                    mq[0]   = e;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin : mon
            int   n;
            ent_t w;
            n = mq.size();
            vectors++;
            if (occupancy != 2'(n) || if_ready != (n < 2) || id_valid != (n > 0)) begin
                miscompares++;
                $display("FAIL ctrl @%0t: got occ=%0d rdy=%b vld=%b want occ=%0d rdy=%b vld=%b",
                         $time, occupancy, if_ready, id_valid, n, n < 2, n > 0);
            end
            if (id_valid && n > 0) begin
                w = mq[0];
                vectors++;
                if (id_instruction != w.instr || id_pcadd4 != w.pcadd4 ||
                    id_restart_pc != w.rpc || id_is_bds != w.bds || id_is_flushed != w.fl) begin
                    miscompares++;
                    $display("FAIL entry @%0t: got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b",
                             $time, id_instruction, id_pcadd4, id_restart_pc, id_is_bds,
                             id_is_flushed, w.instr, w.pcadd4, w.rpc, w.bds, w.fl);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit bds, input bit fl, input bit rdy);
        @(negedge clock);
        #1;
        if_valid       = v;
        if_instruction = ins;
        if_pc          = pc;
        if_pcadd4      = pc + 32'd4;
        if_is_bds      = bds;
        if_flush       = fl;
        id_ready       = rdy;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_ready", 32'(if_ready), 32'd1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_instr", id_instruction, 32'd0);
        chk("rst_pcadd4", id_pcadd4, 32'd0);
        chk("rst_rpc", id_restart_pc, 32'd0);
        chk("rst_flags", {30'd0, id_is_bds, id_is_flushed}, 32'd0);
        @(negedge clock);
        #1 reset = 1'b0;

        // streaming
        cyc(1'b1, 32'hA000_0001, 32'h100, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'hA000_0002, 32'h104, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'hA000_0003, 32'h108, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // backpressure into skid, then drain
        cyc(1'b1, 32'hB000_000A, 32'h300, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB000_000B, 32'h304, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // branch + delay slot
        cyc(1'b1, 32'hC000_0001, 32'h200, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'hC000_0002, 32'h204, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // flush while FULL without consume
        cyc(1'b1, 32'hD000_0001, 32'h400, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hD000_0002, 32'h404, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // ONE holding X; accept Y with flush while X is consumed
        cyc(1'b1, 32'hE000_000A, 32'h500, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hE000_000B, 32'h504, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b0);
        idle(2, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
                $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 2) != 0);
        end
        idle(3, 1'b1);

        // async reset while FULL
        cyc(1'b1, 32'hF000_0001, 32'h600, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hF000_0002, 32'h604, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        @(posedge clock);
        #2;
        chk("full_occ", 32'(occupancy), 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(id_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_ready", 32'(if_ready), 32'd1);
        @(negedge clock);
        #1 reset = 1'b0;
        cyc(1'b1, 32'h1234_5678, 32'h700, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 32'h1234_5679, 32'h704, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifid_elastic_stage.md
# ifid_elastic_stage

Parametrised, elastic successor to the fixed IF/ID pipeline register. It sits between instruction fetch and decode and carries instruction, PC+4, restart PC, branch-delay-slot flag and a flushed flag. Fetch and decode are connected by a valid/ready handshake instead of stall levels. A 2-entry skid buffer keeps `if_ready` fully registered, which breaks the combinational stall path from decode back to fetch.

## Interface
- `INSTR_W`, default 32: instruction width.
- `PC_W`, default 32: width of PC, PC+4 and restart PC.
- `NOP_VALUE`, default 0: instruction value substituted into flushed entries.
- `clock` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-high.
- `if_valid` in 1: fetch presents a beat.
- `if_ready` out 1: stage can accept a beat; registered.
- `if_instruction` in INSTR_W: fetched instruction.
- `if_pc` in PC_W: PC of the fetched instruction.
- `if_pcadd4` in PC_W: PC+4 of the fetched instruction.
- `if_is_bds` in 1: fetched instruction is a branch delay slot.
- `if_flush` in 1: squash all held entries and any beat accepted this cycle.
- `id_valid` out 1: output entry is valid.
- `id_ready` in 1: decode consumes the output entry; equivalent to not ID-stalled.
- `id_instruction` out INSTR_W: output instruction.
- `id_pcadd4` out PC_W: output PC+4.
- `id_restart_pc` out PC_W: restart PC for exceptions and interrupts.
- `id_is_bds` out 1: output entry is a delay slot.
- `id_is_flushed` out 1: output entry was flushed; decode masks interrupt detection while this is high.
- `occupancy` out 2: number of held entries, 0 to 2.

## Operation
- Storage:
  - OUT register, which drives the `id_*` ports.
  - SKID register, which is never visible at the ports.
  - Each entry holds {instr, pcadd4, restart_pc, is_bds, is_flushed}.
- Handshakes:
  - Accept = `if_valid & if_ready`.
  - Consume = `id_valid & id_ready`.
- States:
  - EMPTY (`occupancy`=0), ONE (1), FULL (2).
  - `if_ready` = (state != FULL).
  - `id_valid` = (state != EMPTY).
- Transitions:
  - EMPTY + accept → ONE; the beat is written to OUT.
  - ONE + accept + consume → ONE; the beat is written to OUT.
  - ONE + accept, no consume → FULL; the beat is written to SKID.
  - ONE + consume, no accept → EMPTY.
  - FULL + consume → ONE; SKID moves to OUT. No accept is possible because `if_ready`=0.
  - Any other case: hold all registers.
- Restart PC:
  - Internal register `last_rpc` is updated to `if_pc` on every accepted beat with `if_is_bds`=0.
  - Accepted non-BDS beat: restart_pc = `if_pc`.
  - Accepted BDS beat: restart_pc = `last_rpc`, the PC of the preceding branch.
- Flush (`if_flush`=1), applied after the normal state update in the same edge:
  - Every entry held after the edge has instr = NOP_VALUE and is_flushed = 1. This includes a beat accepted in the same cycle.
  - pcadd4, restart_pc and is_bds are kept in flushed entries for exception bookkeeping.
  - The SKID entry is discarded: FULL → ONE, and ONE/EMPTY follow the normal transitions.
  - `last_rpc` is still updated by an accepted non-BDS beat.
- A non-flushed accept writes is_flushed=0 into its entry.

## Timing
- Reset values:
  - All `id_*` data ports = 0, with `id_instruction` = 0 regardless of NOP_VALUE.
  - `id_valid`=0, `id_is_bds`=0, `id_is_flushed`=0, `occupancy`=0.
  - `if_ready`=1; internal state EMPTY; `last_rpc`=0.
- Reset takes effect immediately, mid-transfer included; held entries are lost.
- Latency: a beat accepted at edge N is visible on `id_*` after edge N when the stage is EMPTY, or when ONE with a simultaneous consume.
- Throughput: 1 beat/cycle sustained while `id_ready`=1.
- `if_ready` drops in the cycle after the stage enters FULL, and rises in the cycle after a consume from FULL.
- Beat ordering is strictly preserved; no beat is lost or duplicated except through flush.
- A consume and a flush in the same cycle: the consumed entry leaves unflushed, and the remaining entries are flushed.

## Test plan
- Streaming:
  - Stimulus: `id_ready`=1, beats with PC 0x100, 0x104, 0x108 on consecutive cycles.
  - Required: `id_valid` is high from the cycle after the first accept; `id_restart_pc` reads 0x100, 0x104, 0x108; `occupancy` stays at 1.
- Backpressure/skid:
  - Stimulus: `id_ready`=0 with two beats A and B presented.
  - Required: `occupancy`=2 and `if_ready`=0. After `id_ready`=1, A then B appear in order, and `if_ready` returns to 1 one cycle after A is consumed.
- Delay slot:
  - Stimulus: branch at PC 0x200 (`if_is_bds`=0), then slot at PC 0x204 (`if_is_bds`=1).
  - Required: the slot entry shows `id_restart_pc`=0x200 and `id_is_bds`=1.
- Flush while FULL:
  - Stimulus: `if_flush`=1 while FULL, with no consume.
  - Required: `occupancy`=1, `id_instruction`=NOP_VALUE, `id_is_flushed`=1, `id_pcadd4` unchanged.
- Flush with accept and consume:
  - Stimulus: stage ONE holding X; same cycle accepts Y with `if_flush`=1 and consumes X.
  - Required: X is consumed intact; the OUT entry holds Y with NOP_VALUE and `id_is_flushed`=1.
- Async reset mid-operation:
  - Stimulus: assert `reset` between edges while FULL.
  - Required: `id_valid`=0, `occupancy`=0 and `if_ready`=1 immediately, before the next edge.
